// File: rtl/fp_div.sv
// Multi-cycle restoring divider for a 27-bit float (1 sign, 8 exp excess-127, 18 mant).
// Define FP_DIV_ROUND_EN to compute a guard bit and round the quotient half-up.
module fp_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in1,
    input  logic [26:0] in2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] quo,
    output logic        dz
);

`ifdef FP_DIV_ROUND_EN
    localparam int unsigned ITERS = 20;
`else
    localparam int unsigned ITERS = 19;
`endif

    typedef enum logic [2:0] {IDLE, NORM, ITER, PACK, DONE} state_t;

    state_t              state_q, state_d;
    logic [26:0]         in1_q, in1_d;
    logic [26:0]         in2_q, in2_d;
    logic [19:0]         r_q, r_d;
    logic [18:0]         b_q, b_d;
    logic [ITERS-1:0]    q_q, q_d;
    logic signed [9:0]   e_q, e_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [26:0]         quo_q, quo_d;
    logic                dz_q, dz_d;

    logic [18:0]         a_n, b_n;
    logic signed [9:0]   e_n, e_fin;
    logic [18:0]         r_sub;
    logic                q_bit;
    logic [17:0]         mant;
    logic                sign;
`ifdef FP_DIV_ROUND_EN
    logic [19:0]         q_rnd;
    logic                unused_bits;
    assign unused_bits = q_rnd[18];
`else
    logic                unused_bits;
    assign unused_bits = q_q[ITERS-1];
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quo       = quo_q;
    assign dz        = dz_q;

    always_comb begin
        state_d = state_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        r_d     = r_q;
        b_d     = b_q;
        q_d     = q_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        dz_d    = dz_q;
        a_n     = {1'b1, in1_q[17:0]};
        b_n     = {1'b1, in2_q[17:0]};
        e_n     = $signed({2'b00, in1_q[25:18]}) - $signed({2'b00, in2_q[25:18]}) + 10'sd127;
        r_sub   = r_q[18:0];
        q_bit   = 1'b0;
        mant    = '0;
        e_fin   = e_q;
        sign    = in1_q[26] ^ in2_q[26];
`ifdef FP_DIV_ROUND_EN
        q_rnd   = {1'b0, q_q[19:1]} + {19'd0, q_q[0]};
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in1_d   = in1;
                    in2_d   = in2;
                    state_d = NORM;
                end
            end
            NORM: begin
                // Pre-shift the dividend so the first quotient bit is always the hidden 1.
                if (a_n < b_n) begin
                    r_d = {a_n, 1'b0};
                    e_d = e_n - 10'sd1;
                end else begin
                    r_d = {1'b0, a_n};
                    e_d = e_n;
                end
                b_d     = b_n;
                q_d     = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                if (r_q >= {1'b0, b_q}) begin
                    r_sub = 19'(r_q - {1'b0, b_q});
                    q_bit = 1'b1;
                end
                r_d   = {r_sub, 1'b0};
                q_d   = {q_q[ITERS-2:0], q_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITERS - 1))
                    state_d = PACK;
            end
            PACK: begin
`ifdef FP_DIV_ROUND_EN
                if (q_rnd[19]) begin
                    mant  = '0;
                    e_fin = e_q + 10'sd1;
                end else begin
                    mant  = q_rnd[17:0];
                    e_fin = e_q;
                end
`else
                mant  = q_q[17:0];
                e_fin = e_q;
`endif
                dz_d = 1'b0;
                if (in2_q[25:18] == 8'h00) begin
                    quo_d = {sign, 8'hFF, 18'h0};
                    dz_d  = 1'b1;
                end else if (in1_q[25:18] == 8'h00) begin
                    quo_d = {sign, 8'h00, 18'h0};
                end else if (e_fin > 10'sd254) begin
                    quo_d = {sign, 8'hFE, 18'h3FFFF};
                end else if (e_fin < 10'sd1) begin
                    quo_d = {sign, 8'h00, 18'h0};
                end else begin
                    quo_d = {sign, e_fin[7:0], mant};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in1_q   <= '0;
            in2_q   <= '0;
            r_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            e_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            r_q     <= r_d;
            b_q     <= b_d;
            q_q     <= q_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
        end
    end

endmodule
